// File: rtl/cu_read_data_unpacker.sv
// Receive end of the CU read path: latches one read-response line and
// streams its elements out one per cycle, byte-reversed into host order.
module cu_read_data_unpacker #(
  parameter  int LINE_BYTES = 128,
  parameter  int ELEM_BYTES = 4,
  parameter  int CU_ID_W    = 8,
  parameter  int COUNT_W    = 32,
  localparam int MAX_ELEMS  = LINE_BYTES / ELEM_BYTES,
  localparam int NUM_W      = $clog2(MAX_ELEMS) + 2
) (
  input  logic                      clock,
  input  logic                      rstn,
  input  logic                      enabled,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CU_ID_W-1:0]        in_cu_id,
  input  logic [0:LINE_BYTES*8-1]   in_data,
  input  logic [NUM_W-1:0]          in_num_elems,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CU_ID_W-1:0]        out_cu_id,
  output logic [0:ELEM_BYTES*8-1]   out_data,
  output logic                      out_last,
  output logic [COUNT_W-1:0]        elem_count
);

  localparam int LB = LINE_BYTES * 8;
  localparam int EB = ELEM_BYTES * 8;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [0:LB-1]    r_line;
  logic [NUM_W-1:0] r_n;
  logic [NUM_W-1:0] r_idx;
  logic [NUM_W-1:0] w_n;
  logic             w_acc;
  logic             w_hs;

  function automatic logic [0:EB-1] f_swap(input logic [0:EB-1] e);
    logic [0:EB-1] s;
    s = '0;
    for (int j = 0; j < ELEM_BYTES; j++) begin
      s[j*8 +: 8] = e[(ELEM_BYTES-1-j)*8 +: 8];
    end
    return s;
  endfunction

  assign in_ready = rstn && enabled && (r_state == IDLE);
  assign w_acc    = in_valid && in_ready;
  assign w_hs     = out_valid && out_ready;
  assign w_n      = (in_num_elems > NUM_W'(MAX_ELEMS))
                  ? NUM_W'(MAX_ELEMS) : in_num_elems;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_acc && (w_n != '0)) w_next = DRAIN;
      DRAIN:   if (w_hs && out_last)     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_line is shifted so the next element to emit always sits at byte 0
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      r_line     <= '0;
      r_n        <= '0;
      r_idx      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_data   <= '0;
      out_cu_id  <= '0;
      elem_count <= '0;
    end else begin
      if (w_hs) begin
        elem_count <= elem_count + COUNT_W'(1);
      end
      if (w_acc) begin
        out_cu_id <= in_cu_id;
        r_n       <= w_n;
        r_idx     <= '0;
        r_line    <= in_data << EB;
        out_data  <= f_swap(in_data[0 +: EB]);
        out_last  <= (w_n == NUM_W'(1));
        out_valid <= (w_n != '0);
      end else if (w_hs) begin
        if (out_last) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else begin
          r_idx    <= r_idx + NUM_W'(1);
          r_line   <= r_line << EB;
          out_data <= f_swap(r_line[0 +: EB]);
          out_last <= ((r_idx + NUM_W'(2)) == r_n);
        end
      end
    end
  end

endmodule

// File: tb/tb_cu_read_data_unpacker.sv
// Directed bench for cu_read_data_unpacker: table of lines plus
// reset, enable and stall sequences.
module tb_cu_read_data_unpacker;

  logic          clock = 1'b0;
  logic          rstn;
  logic          enabled;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_cu_id;
  logic [0:1023] in_data;
  logic [6:0]    in_num_elems;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_cu_id;
  logic [0:31]   out_data;
  logic          out_last;
  logic [31:0]   elem_count;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt = 0;

  always #5 clock = ~clock;

  cu_read_data_unpacker dut (
    .clock        (clock),
    .rstn         (rstn),
    .enabled      (enabled),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_cu_id     (in_cu_id),
    .in_data      (in_data),
    .in_num_elems (in_num_elems),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_cu_id    (out_cu_id),
    .out_data     (out_data),
    .out_last     (out_last),
    .elem_count   (elem_count)
  );

  typedef struct {
    logic [7:0] cu;
    logic [7:0] base;
    logic [6:0] num;
    bit         stall;
    int         exp_n;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [0:31] exp_elem(input logic [7:0] base,
                                           input int k);
    logic [0:31] e;
    for (int j = 0; j < 4; j++) begin
      e[j*8 +: 8] = 8'(int'(base) + k*4 + 3 - j);
    end
    return e;
  endfunction

  task automatic set_line(input logic [7:0] cu, input logic [7:0] base,
                          input logic [6:0] num);
    in_cu_id     = cu;
    in_num_elems = num;
    for (int b = 0; b < 128; b++) begin
      in_data[b*8 +: 8] = 8'(int'(base) + b);
    end
  endtask

  task automatic accept_line(input logic [7:0] cu, input logic [7:0] base,
                             input logic [6:0] num, input int exp_n);
    int t;
    t = 0;
    set_line(cu, base, num);
    in_valid = 1'b1;
    #1;
    while (!in_ready && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("first_valid", out_valid, exp_n > 0);
    if (exp_n == 0) begin
      chk("n0_in_ready", in_ready, 1);
    end
  endtask

  task automatic collect(input logic [7:0] cu, input logic [7:0] base,
                         input int exp_n, input bit stall, input int limit);
    int k;
    int cyc;
    bit tog;
    k = 0;
    cyc = 0;
    tog = 1'b0;
    while (k < limit && cyc < 400) begin
      out_ready = stall ? tog : 1'b1;
      tog = !tog;
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, exp_elem(base, k));
      chk("out_cu_id", out_cu_id, cu);
      chk("out_last", out_last, k == exp_n - 1);
      if (out_ready) begin
        k++;
        exp_cnt++;
      end
      @(posedge clock); #1;
      cyc++;
    end
    out_ready = 1'b1;
    if (k < limit) begin
      chk("collect_timeout", k, limit);
    end
    chk("elem_count", elem_count, 64'(exp_cnt));
    if (k == exp_n) begin
      chk("bubble_valid", out_valid, 0);
      chk("bubble_in_ready", in_ready, enabled);
    end
  endtask

  initial begin
    tv[0] = '{8'hA5, 8'h00, 7'd32,  1'b0, 32};
    tv[1] = '{8'h3C, 8'h00, 7'd32,  1'b1, 32};
    tv[2] = '{8'h01, 8'h40, 7'd0,   1'b0, 0};
    tv[3] = '{8'h02, 8'h80, 7'd40,  1'b0, 32};
    tv[4] = '{8'h11, 8'h10, 7'd2,   1'b0, 2};
    tv[5] = '{8'h22, 8'h50, 7'd1,   1'b0, 1};
    tv[6] = '{8'h7E, 8'hF0, 7'd127, 1'b1, 32};

    rstn = 1'b0;
    enabled = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_line(8'h00, 8'h00, 7'd0);
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cu_id", out_cu_id, 0);
    chk("rst_elem_count", elem_count, 0);
    rstn = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) begin
      accept_line(tv[i].cu, tv[i].base, tv[i].num, tv[i].exp_n);
      if (tv[i].exp_n == 0) begin
        repeat (3) begin
          chk("n0_no_valid", out_valid, 0);
          @(posedge clock); #1;
        end
        chk("n0_elem_count", elem_count, 64'(exp_cnt));
      end else begin
        collect(tv[i].cu, tv[i].base, tv[i].exp_n, tv[i].stall,
                tv[i].exp_n);
      end
    end

    // reset in the middle of a line
    accept_line(8'h44, 8'h00, 7'd32, 32);
    collect(8'h44, 8'h00, 32, 1'b0, 5);
    rstn = 1'b0;
    #1;
    exp_cnt = 0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_elem_count", elem_count, 0);
    chk("midrst_in_ready", in_ready, 0);
    @(posedge clock); #1;
    rstn = 1'b1;
    accept_line(8'h55, 8'h20, 7'd3, 3);
    collect(8'h55, 8'h20, 3, 1'b0, 3);

    // enable low in IDLE blocks acceptance
    enabled = 1'b0;
    set_line(8'h66, 8'h30, 7'd4);
    in_valid = 1'b1;
    #1;
    repeat (3) begin
      chk("dis_in_ready", in_ready, 0);
      @(posedge clock); #1;
      chk("dis_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    enabled = 1'b1;
    accept_line(8'h66, 8'h30, 7'd4, 4);
    enabled = 1'b0;
    collect(8'h66, 8'h30, 4, 1'b1, 4);
    set_line(8'h77, 8'h60, 7'd2);
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clock); #1;
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 0);
    end
    chk("hold_elem_count", elem_count, 64'(exp_cnt));
    enabled = 1'b1;
    accept_line(8'h77, 8'h60, 7'd2, 2);
    collect(8'h77, 8'h60, 2, 1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
